// File: rtl/spi_exe_pkg.sv
// Shared definitions for the SPI execution-unit front end.
//   frame_state_t : states of the frame FSM in spi_exe_frame_if
//   DEF_BITS      : default operand/result width
package spi_exe_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RX_A = 3'd1,
      RX_B = 3'd2,
      EXEC = 3'd3,
      CAPT = 3'd4,
      TX   = 3'd5,
      DONE = 3'd6
   } frame_state_t;

   localparam int DEF_BITS = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with one-cycle rise and
// fall pulses derived from the synchronised value.
//   i_clk   : system clock
//   i_rsn   : synchronous active-low reset; stages load RST_VAL
//   i_d     : asynchronous input level
//   o_rise  : synchronised value went 0 -> 1 (one cycle)
//   o_fall  : synchronised value went 1 -> 0 (one cycle)
module spi_sync_edge #(
   parameter int   SYNC_FF = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rsn,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_FF-1:0] sync_q;
   logic               prev_q;
   logic               sync_s;

   always_ff @(posedge i_clk) begin
      if (!i_rsn) begin
         sync_q <= {SYNC_FF{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_FF-2:0], i_d};
         prev_q <= sync_q[SYNC_FF-1];
      end
   end

   assign sync_s = sync_q[SYNC_FF-1];
   assign o_rise = sync_s & ~prev_q;
   assign o_fall = ~sync_s & prev_q;

endmodule

// File: rtl/spi_exe_frame_if.sv
// SPI-slave (mode 0) frame interface for the SPI execution units.
// Receives two BITS-wide operands MSB first on MOSI, presents them to the
// execution unit with a one-cycle o_valid strobe, captures the unit's
// combinational result and shifts it back on MISO in the same CS-low frame.
// All SPI pins are oversampled on i_clk.
//   i_clk, i_rsn  : system clock, synchronous active-low reset
//   i_sclk        : SPI clock (mode 0), asynchronous
//   i_cs_n        : SPI chip select, active-low, asynchronous
//   i_mosi        : SPI data in, MSB first
//   o_miso        : SPI data out, MSB first, 0 when not transmitting
//   o_argA/o_argB : operands, held until the next complete frame
//   o_valid       : strobe; o_argA/o_argB are new in this cycle. There is no
//                   back-pressure: the unit must consume the operands
//                   combinationally, its result is taken one cycle later.
//   i_result      : combinational result of the execution unit
//   o_busy        : frame in progress (RX through TX)
//   o_dbg_state   : current FSM state, for observation only
module spi_exe_frame_if
   import spi_exe_pkg::*;
#(
   parameter int BITS    = DEF_BITS,
   parameter int SYNC_FF = 2
) (
   input  logic            i_clk,
   input  logic            i_rsn,
   input  logic            i_sclk,
   input  logic            i_cs_n,
   input  logic            i_mosi,
   output logic            o_miso,
   output logic [BITS-1:0] o_argA,
   output logic [BITS-1:0] o_argB,
   output logic            o_valid,
   input  logic [BITS-1:0] i_result,
   output logic            o_busy,
   output logic [2:0]      o_dbg_state
);

   localparam int CW = $clog2(BITS) + 1;

   logic sclk_rise;
   logic sclk_fall;

   spi_sync_edge #(
      .SYNC_FF (SYNC_FF),
      .RST_VAL (1'b0)
   ) u_sclk_sync (
      .i_clk  (i_clk),
      .i_rsn  (i_rsn),
      .i_d    (i_sclk),
      .o_rise (sclk_rise),
      .o_fall (sclk_fall)
   );

   // cs_n and mosi go through the same depth as sclk so that mosi is aligned
   // with the detected rise.
   logic [SYNC_FF-1:0] cs_sync_q;
   logic [SYNC_FF-1:0] mosi_sync_q;
   logic               cs_hi;
   logic               mosi_s;

   always_ff @(posedge i_clk) begin
      if (!i_rsn) begin
         cs_sync_q   <= {SYNC_FF{1'b1}};
         mosi_sync_q <= '0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_FF-2:0], i_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_FF-2:0], i_mosi};
      end
   end

   assign cs_hi  = cs_sync_q[SYNC_FF-1];
   assign mosi_s = mosi_sync_q[SYNC_FF-1];

   frame_state_t      state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*BITS-1:0] shreg_q, shreg_d;
   logic [BITS-1:0]   txreg_q, txreg_d;
   logic [BITS-1:0]   arga_q, arga_d;
   logic [BITS-1:0]   argb_q, argb_d;
   logic              valid_q, valid_d;
   logic              miso_q, miso_d;
   logic              arm_q, arm_d;

   always_ff @(posedge i_clk) begin
      if (!i_rsn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         txreg_q <= '0;
         arga_q  <= '0;
         argb_q  <= '0;
         valid_q <= 1'b0;
         miso_q  <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         txreg_q <= txreg_d;
         arga_q  <= arga_d;
         argb_q  <= argb_d;
         valid_q <= valid_d;
         miso_q  <= miso_d;
         arm_q   <= arm_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      txreg_d = txreg_q;
      arga_d  = arga_q;
      argb_d  = argb_q;
      valid_d = 1'b0;
      miso_d  = miso_q;
      arm_d   = arm_q;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (!cs_hi) state_d = RX_A;
         end

         // One 2*BITS shift register holds A in the upper half and B in the
         // lower half, so an aborted frame never touches the operand outputs.
         RX_A, RX_B: begin
            if (cs_hi) begin
               state_d = IDLE;
               miso_d  = 1'b0;
            end else if (sclk_rise) begin
               shreg_d = {shreg_q[2*BITS-2:0], mosi_s};
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(BITS-1)) begin
                  state_d = (state_q == RX_A) ? RX_B : EXEC;
               end
            end
         end

         // Operands and strobe land together; the strobe completes even if
         // cs_n has already gone high.
         EXEC: begin
            arga_d  = shreg_q[2*BITS-1:BITS];
            argb_d  = shreg_q[BITS-1:0];
            valid_d = 1'b1;
            state_d = cs_hi ? IDLE : CAPT;
         end

         CAPT: begin
            if (cs_hi) begin
               state_d = IDLE;
               miso_d  = 1'b0;
            end else begin
               txreg_d = i_result;
               miso_d  = i_result[BITS-1];
               arm_d   = 1'b0;
               state_d = TX;
            end
         end

         // The trailing fall of the last RX bit can arrive after TX is
         // entered; only falls that follow a TX-phase rise shift data out.
         TX: begin
            if (cs_hi) begin
               state_d = IDLE;
               miso_d  = 1'b0;
            end else begin
               if (sclk_rise) arm_d = 1'b1;
               if (sclk_fall && arm_q) begin
                  txreg_d = {txreg_q[BITS-2:0], txreg_q[BITS-1]};
                  miso_d  = txreg_q[BITS-2];
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q == CW'(BITS-2)) state_d = DONE;
               end
            end
         end

         DONE: begin
            if (cs_hi) begin
               state_d = IDLE;
               miso_d  = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            miso_d  = 1'b0;
         end
      endcase

      if (state_d != state_q) cnt_d = '0;
   end

   assign o_miso      = miso_q;
   assign o_argA      = arga_q;
   assign o_argB      = argb_q;
   assign o_valid     = valid_q;
   assign o_busy      = (state_q != IDLE) && (state_q != DONE);
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_spi_exe_frame_if.sv
// Bench for spi_exe_frame_if: an SPI master task drives frames, a one-hot to
// binary unit model is attached to the operand outputs, and a per-cycle
// monitor checks operands, strobe and idle/reset behaviour against a
// transaction-level expectation queue.
module tb_spi_exe_frame_if;

   logic       clk  = 1'b0;
   logic       rsn  = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic [7:0] arga;
   logic [7:0] argb;
   logic       valid;
   logic [7:0] result;
   logic       busy;
   logic [2:0] dbg_state;

   int checks    = 0;
   int failures  = 0;
   int valid_cnt = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_e;
   logic [7:0]  mdl_a      = 8'h00;
   logic [7:0]  mdl_b      = 8'h00;
   logic        prev_valid = 1'b0;
   logic        rst_seen   = 1'b1;
   int          cs_hi_cnt  = 0;

   always #5 clk = ~clk;

   spi_exe_frame_if #(
      .BITS    (8),
      .SYNC_FF (2)
   ) dut (
      .i_clk       (clk),
      .i_rsn       (rsn),
      .i_sclk      (sclk),
      .i_cs_n      (cs_n),
      .i_mosi      (mosi),
      .o_miso      (miso),
      .o_argA      (arga),
      .o_argB      (argb),
      .o_valid     (valid),
      .i_result    (result),
      .o_busy      (busy),
      .o_dbg_state (dbg_state)
   );

   // Index of the single hot bit, 0 when zero or several bits are set.
   function automatic logic [7:0] onehot2bin(input logic [7:0] v);
      int         n;
      logic [7:0] idx;
      n   = 0;
      idx = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            n++;
            idx = 8'(i);
         end
      end
      return (n == 1) ? idx : 8'h00;
   endfunction

   always_comb result = onehot2bin(arga);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      rst_seen  <= !rsn;
      cs_hi_cnt <= cs_n ? cs_hi_cnt + 1 : 0;
   end

   always @(negedge clk) begin
      if (rst_seen) begin
         chk("rst_miso", {31'd0, miso}, 0);
         chk("rst_busy", {31'd0, busy}, 0);
         chk("rst_valid", {31'd0, valid}, 0);
         chk("rst_arga", {24'd0, arga}, 0);
         chk("rst_argb", {24'd0, argb}, 0);
         chk("rst_state", {29'd0, dbg_state}, 0);
         mdl_a = 8'h00;
         mdl_b = 8'h00;
         exp_q.delete();
         prev_valid = 1'b0;
      end else begin
         if (valid) begin
            valid_cnt++;
            chk("valid_width", {31'd0, prev_valid}, 0);
            if (exp_q.size() == 0) begin
               chk("valid_unexpected", 1, 0);
            end else begin
               exp_e = exp_q.pop_front();
               mdl_a = exp_e[15:8];
               mdl_b = exp_e[7:0];
            end
         end
         chk("arg_a", {24'd0, arga}, {24'd0, mdl_a});
         chk("arg_b", {24'd0, argb}, {24'd0, mdl_b});
         if (cs_hi_cnt >= 6) begin
            chk("idle_miso", {31'd0, miso}, 0);
            chk("idle_busy", {31'd0, busy}, 0);
            chk("idle_valid", {31'd0, valid}, 0);
         end
         prev_valid = valid;
      end
   end

   // ---------------- SPI master ----------------
   // h: SCLK half period in clk cycles; abort_rx: raise cs_n before RX bit
   // abort_rx (-1 none); rst_bit: pulse reset before TX bit rst_bit (-1 none);
   // gap_per: cs_n high time afterwards in SCLK periods.
   task automatic frame(input logic [7:0] a, input logic [7:0] b, input int h,
                        input int abort_rx, input int rst_bit, input int gap_per,
                        output logic [7:0] rx);
      logic [15:0] w;
      w  = {a, b};
      rx = 8'h00;
      cs_n = 1'b0;
      wclk(h);
      for (int i = 0; i < 16; i++) begin
         if (i == abort_rx) begin
            cs_n = 1'b1;
            wclk(gap_per * 2 * h);
            return;
         end
         mosi = w[15-i];
         if (i == 15) exp_q.push_back(w);
         wclk(h);
         sclk = 1'b1;
         wclk(h);
         sclk = 1'b0;
      end
      wclk(8);
      for (int k = 0; k < 8; k++) begin
         if (k == rst_bit) begin
            rsn = 1'b0;
            wclk(1);
            chk("rst_tx_miso", {31'd0, miso}, 0);
            sclk = 1'b0;
            cs_n = 1'b1;
            wclk(2);
            rsn = 1'b1;
            wclk(gap_per * 2 * h);
            return;
         end
         rx[7-k] = miso;
         chk("busy_tx", {31'd0, busy}, {31'd0, (k < 7)});
         sclk = 1'b1;
         wclk(h);
         sclk = 1'b0;
         wclk(h);
      end
      wclk(2);
      chk("busy_done", {31'd0, busy}, 0);
      cs_n = 1'b1;
      mosi = 1'($urandom_range(0, 1));
      wclk(gap_per * 2 * h);
   endtask

   task automatic full(input logic [7:0] a, input string name, input logic [7:0] lit);
      logic [7:0] rx;
      int         v0;
      v0 = valid_cnt;
      frame(a, 8'($urandom_range(0, 255)), 4, -1, -1, 3, rx);
      chk({name, "_valid"}, valid_cnt - v0, 1);
      chk({name, "_rx"}, {24'd0, rx}, {24'd0, lit});
      chk({name, "_model"}, {24'd0, onehot2bin(a)}, {24'd0, lit});
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] ra;
      int         v0;
      int         h;
      int         ab;

      // reset with random SPI pins
      rsn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sclk = 1'($urandom_range(0, 1));
         cs_n = 1'($urandom_range(0, 1));
         mosi = 1'($urandom_range(0, 1));
         wclk(1);
      end
      sclk = 1'b0;
      cs_n = 1'b1;
      wclk(1);
      rsn = 1'b1;
      wclk(6);
      chk("post_rst_state", {29'd0, dbg_state}, 0);
      chk("post_rst_miso", {31'd0, miso}, 0);

      full(8'h10, "f10", 8'h04);
      chk("f10_arga", {24'd0, arga}, 32'h10);
      full(8'h12, "f12", 8'h00);
      full(8'h00, "f00", 8'h00);
      full(8'h80, "f80", 8'h07);

      // abort after 11 RX bits
      v0 = valid_cnt;
      frame(8'h5a, 8'hc3, 4, 11, -1, 3, rx);
      chk("abort_valid", valid_cnt - v0, 0);
      chk("abort_arga", {24'd0, arga}, 32'h80);
      full(8'h01, "f01", 8'h00);

      // reset during TX bit 3
      frame(8'h08, 8'h00, 4, -1, 3, 3, rx);
      chk("rst_arga_after", {24'd0, arga}, 0);
      full(8'h40, "f40", 8'h06);

      // back-to-back frames, cs_n high for 2 SCLK periods
      v0 = valid_cnt;
      frame(8'h02, 8'h11, 4, -1, -1, 2, rx);
      chk("b2b1_rx", {24'd0, rx}, 32'h01);
      frame(8'h20, 8'h22, 4, -1, -1, 2, rx);
      chk("b2b2_rx", {24'd0, rx}, 32'h05);
      chk("b2b_valid", valid_cnt - v0, 2);
      wclk(10);

      // randomized frames
      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 1) == 0) ra = 8'(1 << $urandom_range(0, 7));
         else ra = 8'($urandom_range(0, 255));
         h  = $urandom_range(4, 6);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : -1;
         v0 = valid_cnt;
         frame(ra, 8'($urandom_range(0, 255)), h, ab, -1, $urandom_range(2, 4), rx);
         if (ab < 0) begin
            chk("rnd_rx", {24'd0, rx}, {24'd0, onehot2bin(ra)});
            chk("rnd_valid", valid_cnt - v0, 1);
         end else begin
            chk("rnd_abort_valid", valid_cnt - v0, 0);
         end
      end

      wclk(10);
      chk("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
